// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the RV32M iterative divider: default widths, the
// OP encoding seen on the pipeline interface, FSM state encoding and the
// special-case result constants.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  // Operation select as driven by the decoder: bit 1 picks remainder,
  // bit 0 picks unsigned.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Most negative signed value and the all-ones pattern at the default width.
  localparam logic [XLEN_DEFAULT-1:0] INT_MIN  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};
  localparam logic [XLEN_DEFAULT-1:0] ALL_ONES = '1;

endpackage

// File: rtl/div_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
// Unsigned restoring-division datapath, one quotient bit per step, MSB first.
// The quotient register starts out holding the dividend; each step shifts the
// next dividend bit out of its top and a quotient bit into its bottom.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   load                load operands, clear remainder, counter = XLEN-1
//   step                perform one iteration
//   dividend, divisor   unsigned operand magnitudes (sampled on load)
//   last                counter is 0: the next step is the final one
//   quo_next, rem_next  quotient/remainder after the current step
// -----------------------------------------------------------------------------
module div_iter_core
  import div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]    shifted;
  logic [XLEN+1:0]  trial;
  logic             ge;

  // The full remainder is kept in the shift: when the divisor exceeds
  // 2^(XLEN-1) the partial remainder can occupy every bit. The extra top bit
  // of the trial is the borrow; a non-negative trial is always below the
  // divisor, so both upper bits are zero exactly when the subtract succeeds.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign ge       = (trial[XLEN+1:XLEN] == 2'b00);

  assign rem_next = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_next = {quo_q[XLEN-2:0], ge};
  assign last     = (cnt_q == '0);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(XLEN - 1);
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative divider for RV32M DIV/DIVU/REM/REMU. Takes operands from the
// register file read ports and returns a writeback request (address, data,
// enable) for the register file write port. One operation in flight.
//
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   START          request a divide (sampled only in IDLE)
//   OP             00 DIV, 01 DIVU, 10 REM, 11 REMU
//   RS1, RS2       dividend, divisor
//   RD             destination register
//   FLUSH          abort in-flight op; suppresses DONE/WB_EN in the same cycle
//   BUSY           high in CALC and DONE
//   DONE           one-cycle result-valid pulse
//   WB_EN          DONE and WB_ADDR != 0
//   WB_ADDR        latched RD
//   WB_DATA        quotient or remainder, held until the next result
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [XLEN-1:0]   RS1,
  input  logic [XLEN-1:0]   RS2,
  input  logic [REG_AW-1:0] RD,
  input  logic              FLUSH,
  output logic              BUSY,
  output logic              DONE,
  output logic              WB_EN,
  output logic [REG_AW-1:0] WB_ADDR,
  output logic [XLEN-1:0]   WB_DATA
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e state;
  op_e    op_q;
  logic   signs_differ_q;
  logic   rs1_neg_q;

  // Start-time decode
  logic            in_signed;
  logic            in_rem;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            div_by_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  // Core interface
  logic            core_load;
  logic            core_step;
  logic            core_last;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] result;

  assign in_signed   = ~OP[0];
  assign in_rem      = OP[1];
  assign rs1_neg     = in_signed & RS1[XLEN-1];
  assign rs2_neg     = in_signed & RS2[XLEN-1];
  assign rs1_mag     = rs1_neg ? -RS1 : RS1;
  assign rs2_mag     = rs2_neg ? -RS2 : RS2;
  assign div_by_zero = (RS2 == '0);
  assign overflow    = in_signed & (RS1 == MIN_VAL) & (RS2 == '1);
  assign special     = div_by_zero | overflow;

  // FLUSH wins over a simultaneous START.
  assign accept      = (state == ST_IDLE) & START & ~FLUSH;
  assign core_load   = accept & ~special;
  assign core_step   = (state == ST_CALC) & ~FLUSH;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    special_res = '1;
    if (overflow) begin
      special_res = in_rem ? '0 : MIN_VAL;
    end else if (in_rem) begin
      special_res = RS1;
    end
  end

  // Sign fix-up on the value produced by the final step.
  always_comb begin
    result = quo_next;
    unique case (op_q)
      OP_DIV:  result = signs_differ_q ? -quo_next : quo_next;
      OP_DIVU: result = quo_next;
      OP_REM:  result = rs1_neg_q ? -rem_next : rem_next;
      default: result = rem_next;
    endcase
  end

  div_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (core_load),
    .step    (core_step),
    .dividend(rs1_mag),
    .divisor (rs2_mag),
    .last    (core_last),
    .quo_next(quo_next),
    .rem_next(rem_next)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= ST_IDLE;
      op_q           <= OP_DIV;
      signs_differ_q <= 1'b0;
      rs1_neg_q      <= 1'b0;
      WB_ADDR        <= '0;
      WB_DATA        <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q           <= op_e'(OP);
            signs_differ_q <= rs1_neg ^ rs2_neg;
            rs1_neg_q      <= rs1_neg;
            WB_ADDR        <= RD;
            if (special) begin
              WB_DATA <= special_res;
              state   <= ST_DONE;
            end else begin
              state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (FLUSH) begin
            state <= ST_IDLE;
          end else if (core_last) begin
            WB_DATA <= result;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign DONE  = (state == ST_DONE) & ~FLUSH;
  assign WB_EN = DONE & (WB_ADDR != '0);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic [4:0]  RD;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic        WB_EN;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  div_unit #(.XLEN(32), .REG_AW(5)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .OP     (OP),
    .RS1    (RS1),
    .RS2    (RS2),
    .RD     (RD),
    .FLUSH  (FLUSH),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .WB_EN  (WB_EN),
    .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 of cycle 1.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    START = 1'b1; OP = op; RS1 = a; RS2 = b; RD = rd;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Entered at posedge+1 of cycle 'first'; returns at posedge+1 of the cycle
  // after DONE. cyc stays -1 when no DONE is seen within the budget.
  task automatic wait_done(input int first, output int cyc, output logic en,
                           output logic [4:0] addr, output logic [31:0] data);
    cyc = -1; en = 1'b0; addr = '0; data = '0;
    for (int c = first; c <= 45; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        cyc = c; en = WB_EN; addr = WB_ADDR; data = WB_DATA;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; OP = '0; RS1 = '0; RS2 = '0; RD = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b want 0", WB_EN); end
    checks++; if (WB_ADDR !== 5'd0) begin errors++; $display("FAIL reset_wb_addr: got %0d want 0", WB_ADDR); end
    checks++; if (WB_DATA !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", WB_DATA); end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_unsigned();
    int cyc; logic en; logic [4:0] addr; logic [31:0] data;
    start_op(OP_DIVU, 32'd100, 32'd7, 5'd5);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL divu_busy_c1: got %b want 1", BUSY); end
    wait_done(1, cyc, en, addr, data);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divu_done_cycle: got %0d want 33", cyc); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL divu_wb_en: got %b want 1", en); end
    checks++; if (addr !== 5'd5) begin errors++; $display("FAIL divu_wb_addr: got %0d want 5", addr); end
    checks++; if (data !== 32'd14) begin errors++; $display("FAIL divu_wb_data: got %h want %h", data, 32'd14); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL divu_busy_c34: got %b want 0", BUSY); end
    checks++; if (WB_DATA !== 32'd14) begin errors++; $display("FAIL divu_hold: got %h want %h", WB_DATA, 32'd14); end
    start_op(OP_REMU, 32'd100, 32'd7, 5'd5);
    wait_done(1, cyc, en, addr, data);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL remu_done_cycle: got %0d want 33", cyc); end
    checks++; if (data !== 32'd2) begin errors++; $display("FAIL remu_wb_data: got %h want %h", data, 32'd2); end
  endtask

  // Signed, large-divisor and special-case vectors with hand-computed results.
  task automatic test_vectors();
    vec_t v[14];
    int cyc; logic en; logic [4:0] addr; logic [31:0] data;
    v[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33}; // -7 / 2
    v[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33}; // -7 % 2
    v[2]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33}; // 7 / -2
    v[3]  = '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33}; // 7 % -2
    v[4]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         33};
    v[5]  = '{OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33};
    v[6]  = '{OP_DIV,  INT_MIN,       32'd3,         32'hD555_5556, 33}; // -715827882
    v[7]  = '{OP_REM,  INT_MIN,       32'd3,         32'hFFFF_FFFE, 33}; // -2
    v[8]  = '{OP_DIVU, 32'd5,         32'd0,         ALL_ONES,      1};
    v[9]  = '{OP_REM,  32'd5,         32'd0,         32'd5,         1};
    v[10] = '{OP_DIV,  32'hFFFF_FFFB, 32'd0,         ALL_ONES,      1};
    v[11] = '{OP_REMU, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
    v[12] = '{OP_DIV,  INT_MIN,       ALL_ONES,      INT_MIN,       1};
    v[13] = '{OP_REM,  INT_MIN,       ALL_ONES,      32'd0,         1};
    for (int i = 0; i < 14; i++) begin
      start_op(v[i].op, v[i].a, v[i].b, 5'd17);
      wait_done(1, cyc, en, addr, data);
      checks++; if (cyc !== v[i].cyc) begin errors++; $display("FAIL vec%0d_cycle: got %0d want %0d", i, cyc, v[i].cyc); end
      checks++; if (data !== v[i].exp) begin errors++; $display("FAIL vec%0d_data: got %h want %h", i, data, v[i].exp); end
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL vec%0d_wb_en: got %b want 1", i, en); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL vec%0d_idle_after: got %b want 0", i, BUSY); end
    end
  endtask

  task automatic test_rd_zero_and_restart();
    int done_cnt; int cyc; logic en; logic [4:0] addr; logic [31:0] data;
    START = 1'b1; OP = OP_DIV; RS1 = 32'd20; RS2 = 32'd3; RD = 5'd0;
    @(posedge CLK); #1;
    // START stays high with new operands: ignored while busy, taken in cycle 34.
    OP = OP_DIVU; RS1 = 32'd50; RS2 = 32'd5; RD = 5'd9;
    done_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_cnt++;
      if (c == 33) begin
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL rd0_done: got %b want 1", DONE); end
        checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL rd0_wb_en: got %b want 0", WB_EN); end
        checks++; if (WB_ADDR !== 5'd0) begin errors++; $display("FAIL rd0_wb_addr: got %0d want 0", WB_ADDR); end
        checks++; if (WB_DATA !== 32'd6) begin errors++; $display("FAIL rd0_wb_data: got %h want %h", WB_DATA, 32'd6); end
      end
      @(posedge CLK); #1;
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rd0_done_count: got %0d want 1", done_cnt); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL restart_busy_c34: got %b want 0", BUSY); end
    @(posedge CLK); #1;
    START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL restart_accepted: got %b want 1", BUSY); end
    wait_done(1, cyc, en, addr, data);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL restart_cycle: got %0d want 33", cyc); end
    checks++; if (data !== 32'd10) begin errors++; $display("FAIL restart_data: got %h want %h", data, 32'd10); end
    checks++; if (addr !== 5'd9 || en !== 1'b1) begin errors++; $display("FAIL restart_wb: got addr %0d en %b want addr 9 en 1", addr, en); end
  endtask

  task automatic test_flush();
    int cyc; logic en; logic [4:0] addr; logic [31:0] data;
    start_op(OP_DIVU, 32'd1000, 32'd3, 5'd4);
    repeat (9) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;                                 // cycle 10
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_c10: got %b want 1", BUSY); end
    @(posedge CLK); #1;
    FLUSH = 1'b0;                                 // cycle 11
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy_c11: got %b want 0", BUSY); end
    start_op(OP_DIVU, 32'd9, 32'd3, 5'd6);        // started in cycle 11
    wait_done(1, cyc, en, addr, data);            // any stray DONE shows up early
    checks++; if (cyc !== 33) begin errors++; $display("FAIL flush_new_cycle: got %0d want 33 (cycle 44)", cyc); end
    checks++; if (data !== 32'd3) begin errors++; $display("FAIL flush_new_data: got %h want %h", data, 32'd3); end
    checks++; if (addr !== 5'd6 || en !== 1'b1) begin errors++; $display("FAIL flush_new_wb: got addr %0d en %b want addr 6 en 1", addr, en); end

    // FLUSH during the DONE cycle of a special-case op.
    start_op(OP_DIVU, 32'd5, 32'd0, 5'd3);
    FLUSH = 1'b1;
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL flush_done_masked: got %b want 0", DONE); end
    checks++; if (WB_EN !== 1'b0) begin errors++; $display("FAIL flush_wb_en_masked: got %b want 0", WB_EN); end
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_done_idle: got %b want 0", BUSY); end

    // FLUSH together with START in IDLE: START is dropped.
    START = 1'b1; FLUSH = 1'b1; OP = OP_DIVU; RS1 = 32'd8; RS2 = 32'd2; RD = 5'd2;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", BUSY); end
    checks++; if (WB_ADDR !== 5'd3) begin errors++; $display("FAIL flush_start_addr: got %0d want 3", WB_ADDR); end
  endtask

  task automatic test_async_reset();
    int done_cnt;
    start_op(OP_DIVU, 32'd100, 32'd7, 5'd5);
    repeat (14) begin @(posedge CLK); #1; end      // cycle 15
    #2 RESET = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0 || WB_EN !== 1'b0) begin errors++; $display("FAIL arst_done_wb_en: got %b%b want 00", DONE, WB_EN); end
    checks++; if (WB_ADDR !== 5'd0) begin errors++; $display("FAIL arst_wb_addr: got %0d want 0", WB_ADDR); end
    checks++; if (WB_DATA !== 32'd0) begin errors++; $display("FAIL arst_wb_data: got %h want 0", WB_DATA); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL arst_no_done: got %0d active cycles want 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_vectors();
    test_rd_zero_and_restart();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
